// File: rtl/sprite_frame_sequencer_if.sv
// Control/status bundle between the frame sequencer and the game-loop logic
// (rate divider, init engine, sprite data registers and pixel muxes).
interface sprite_frame_sequencer_if #(
   parameter int NUM_SPRITES = 3,
   parameter int SPRITE_W    = 5,
   parameter int SPRITE_H    = 5
);
   localparam int NPIX  = SPRITE_W * SPRITE_H;
   localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int LOC_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int DX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int DY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

   logic                   go;
   logic                   init_done;
   logic                   dead;
   logic [NUM_SPRITES-1:0] sprite_en;

   logic [2:0]             state;
   logic [SEL_W-1:0]       sprite_sel;
   logic [LOC_W-1:0]       loc;
   logic [DX_W-1:0]        dx;
   logic [DY_W-1:0]        dy;
   logic                   plot_en;
   logic                   erase;
   logic                   load;
   logic                   go_init;
   logic                   frame_done;
   logic                   restart;
   logic                   overrun;

   modport master (
      output go, init_done, dead, sprite_en,
      input  state, sprite_sel, loc, dx, dy, plot_en, erase, load, go_init,
             frame_done, restart, overrun
   );

   modport slave (
      input  go, init_done, dead, sprite_en,
      output state, sprite_sel, loc, dx, dy, plot_en, erase, load, go_init,
             frame_done, restart, overrun
   );
endinterface

// File: rtl/sprite_frame_sequencer.sv
// Per-frame sequencer: one-shot init, then erase, reload, redraw and collision
// check of every enabled sprite, with restart on death and overrun reporting.
module sprite_frame_sequencer #(
   parameter int NUM_SPRITES = 3,
   parameter int SPRITE_W    = 5,
   parameter int SPRITE_H    = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   sprite_frame_sequencer_if.slave  bus
);
   localparam int NPIX  = SPRITE_W * SPRITE_H;
   localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int LOC_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int DX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int DY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SPRITES - 1);
   localparam logic [LOC_W-1:0] LOC_LAST = LOC_W'(NPIX - 1);
   localparam logic [DX_W-1:0]  DX_LAST  = DX_W'(SPRITE_W - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ERASE = 3'd2,
      LOAD  = 3'd3,
      DRAW  = 3'd4,
      COMP  = 3'd5
   } state_t;

   state_t                  state_q;
   logic [SEL_W-1:0]        sel_q;
   logic [LOC_W-1:0]        loc_q;
   logic [DX_W-1:0]         dx_q;
   logic [DY_W-1:0]         dy_q;
   logic                    init_pending_q;
   logic                    cur_en_q;
   logic                    frame_done_q;
   logic                    restart_q;

   logic [(1<<SEL_W)-1:0]   en_padded;
   logic [SEL_W-1:0]        sel_inc;
   logic                    sprite_end;
   logic                    last_sprite;

   // Pad the mask to a power of two so the sprite index never reaches past it.
   always_comb begin
      en_padded                  = '0;
      en_padded[NUM_SPRITES-1:0] = bus.sprite_en;
   end

   assign sel_inc     = sel_q + SEL_W'(1);
   assign sprite_end  = !cur_en_q || (loc_q == LOC_LAST);
   assign last_sprite = (sel_q == SEL_LAST);

   // cur_en_q holds the enable bit captured on the edge that starts a sprite,
   // so a mask change mid-sprite cannot truncate or stretch its scan.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         sel_q          <= '0;
         loc_q          <= '0;
         dx_q           <= '0;
         dy_q           <= '0;
         init_pending_q <= 1'b1;
         cur_en_q       <= 1'b0;
         frame_done_q   <= 1'b0;
         restart_q      <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         restart_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               sel_q <= '0;
               loc_q <= '0;
               dx_q  <= '0;
               dy_q  <= '0;
               if (bus.go) begin
                  cur_en_q <= en_padded[0];
                  state_q  <= init_pending_q ? INIT : ERASE;
               end
            end
            INIT: begin
               if (bus.init_done) begin
                  init_pending_q <= 1'b0;
                  cur_en_q       <= en_padded[0];
                  state_q        <= ERASE;
               end
            end
            ERASE, DRAW: begin
               if (sprite_end) begin
                  loc_q <= '0;
                  dx_q  <= '0;
                  dy_q  <= '0;
                  if (last_sprite) begin
                     sel_q   <= '0;
                     state_q <= (state_q == ERASE) ? LOAD : COMP;
                  end else begin
                     sel_q    <= sel_inc;
                     cur_en_q <= en_padded[sel_inc];
                  end
               end else begin
                  loc_q <= loc_q + LOC_W'(1);
                  if (dx_q == DX_LAST) begin
                     dx_q <= '0;
                     dy_q <= dy_q + DY_W'(1);
                  end else begin
                     dx_q <= dx_q + DX_W'(1);
                  end
               end
            end
            LOAD: begin
               cur_en_q <= en_padded[0];
               state_q  <= DRAW;
            end
            COMP: begin
               if (bus.dead) begin
                  restart_q <= 1'b1;
                  cur_en_q  <= en_padded[0];
                  state_q   <= ERASE;
               end else begin
                  frame_done_q <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.state      = state_q;
   assign bus.sprite_sel = sel_q;
   assign bus.loc        = loc_q;
   assign bus.dx         = dx_q;
   assign bus.dy         = dy_q;
   assign bus.plot_en    = ((state_q == ERASE) || (state_q == DRAW)) && cur_en_q;
   assign bus.erase      = (state_q == ERASE);
   assign bus.load       = (state_q == LOAD);
   assign bus.go_init    = (state_q == INIT);
   assign bus.frame_done = frame_done_q;
   assign bus.restart    = restart_q;
   assign bus.overrun    = bus.go && (state_q != IDLE);
endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Self-checking bench for sprite_frame_sequencer: each frame is predicted as a
// list of per-cycle expectations built from the mask, then walked against the DUT.
module tb_sprite_frame_sequencer;
   localparam int NS   = 3;
   localparam int W    = 5;
   localparam int H    = 5;
   localparam int NPIX = W * H;

   localparam int ST_IDLE  = 0;
   localparam int ST_INIT  = 1;
   localparam int ST_ERASE = 2;
   localparam int ST_LOAD  = 3;
   localparam int ST_DRAW  = 4;
   localparam int ST_COMP  = 5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   sprite_frame_sequencer_if #(.NUM_SPRITES(NS), .SPRITE_W(W), .SPRITE_H(H)) bus ();

   sprite_frame_sequencer #(.NUM_SPRITES(NS), .SPRITE_W(W), .SPRITE_H(H)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int st;
      int sel;
      int loc;
      int plot;
   } exp_t;

   exp_t exp_q[$];

   function automatic void push_phase(input int st, input logic [NS-1:0] mask);
      for (int s = 0; s < NS; s++) begin
         if (mask[s]) begin
            for (int p = 0; p < NPIX; p++) exp_q.push_back('{st, s, p, 1});
         end else begin
            exp_q.push_back('{st, s, 0, 0});
         end
      end
   endfunction

   function automatic void build_frame(input logic [NS-1:0] mask);
      exp_q.delete();
      push_phase(ST_ERASE, mask);
      exp_q.push_back('{ST_LOAD, 0, 0, 0});
      push_phase(ST_DRAW, mask);
      exp_q.push_back('{ST_COMP, 0, 0, 0});
   endfunction

   function automatic int frame_len(input logic [NS-1:0] mask);
      int nen = 0;
      for (int s = 0; s < NS; s++) if (mask[s]) nen++;
      return 2 * (nen * NPIX + (NS - nen)) + 2;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulses go in IDLE and, if expected, walks INIT for init_cycles cycles.
   task automatic start_frame(input logic want_init, input int init_cycles);
      bus.go = 1'b1;
      #1;
      checks++;
      if (bus.state !== 3'(ST_IDLE) || bus.overrun !== 1'b0) begin
         failures++;
         $display("[TB] FAIL go_in_idle: got state=%0d overrun=%b, want state=0 overrun=0",
                  bus.state, bus.overrun);
      end
      tick();
      bus.go = 1'b0;
      if (want_init) begin
         for (int i = 0; i < init_cycles; i++) begin
            bus.init_done = (i == init_cycles - 1);
            #1;
            checks++;
            if (bus.state !== 3'(ST_INIT) || bus.go_init !== 1'b1 || bus.plot_en !== 1'b0) begin
               failures++;
               $display("[TB] FAIL init_wait cyc=%0d: got state=%0d go_init=%b plot=%b, want 1/1/0",
                        i, bus.state, bus.go_init, bus.plot_en);
            end
            tick();
         end
         bus.init_done = 1'b0;
      end
   endtask

   // Walks one frame from the first ERASE cycle; optional go injection and early abort.
   task automatic run_frame(input logic [NS-1:0] mask, input logic dead_v, input int go_at,
                            input int abort_at, input logic by_restart);
      exp_t e;
      build_frame(mask);
      for (int i = 0; i < exp_q.size(); i++) begin
         e = exp_q[i];
         bus.go   = (i == go_at);
         bus.dead = (e.st == ST_COMP) ? dead_v : 1'b0;
         #1;
         checks++;
         if (bus.state !== e.st || bus.sprite_sel !== e.sel || bus.loc !== e.loc ||
             bus.dx !== (e.loc % W) || bus.dy !== (e.loc / W) || bus.plot_en !== e.plot ||
             bus.erase !== (e.st == ST_ERASE) || bus.load !== (e.st == ST_LOAD) ||
             bus.go_init !== 1'b0 || bus.overrun !== (i == go_at) ||
             bus.restart !== (i == 0 && by_restart) || bus.frame_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL trace idx=%0d: got st=%0d sel=%0d loc=%0d dx=%0d dy=%0d plot=%b er=%b ld=%b gi=%b ov=%b rs=%b fd=%b; want st=%0d sel=%0d loc=%0d dx=%0d dy=%0d plot=%0d ov=%b rs=%b",
                     i, bus.state, bus.sprite_sel, bus.loc, bus.dx, bus.dy, bus.plot_en,
                     bus.erase, bus.load, bus.go_init, bus.overrun, bus.restart, bus.frame_done,
                     e.st, e.sel, e.loc, e.loc % W, e.loc / W, e.plot, (i == go_at),
                     (i == 0 && by_restart));
         end
         if (i == abort_at) begin
            bus.go = 1'b0;
            return;
         end
         tick();
      end
      bus.go   = 1'b0;
      bus.dead = 1'b0;
      #1;
      checks++;
      if (dead_v) begin
         if (bus.state !== 3'(ST_ERASE) || bus.restart !== 1'b1 || bus.frame_done !== 1'b0 ||
             bus.sprite_sel !== '0 || bus.loc !== '0) begin
            failures++;
            $display("[TB] FAIL restart_end: got st=%0d rs=%b fd=%b sel=%0d loc=%0d, want 2/1/0/0/0",
                     bus.state, bus.restart, bus.frame_done, bus.sprite_sel, bus.loc);
         end
      end else begin
         if (bus.state !== 3'(ST_IDLE) || bus.frame_done !== 1'b1 || bus.restart !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_end: got st=%0d fd=%b rs=%b, want 0/1/0",
                     bus.state, bus.frame_done, bus.restart);
         end
      end
   endtask

   task automatic check_idle_quiet(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         #1;
         checks++;
         if (bus.state !== 3'(ST_IDLE) || bus.plot_en !== 1'b0 || bus.frame_done !== 1'b0 ||
             bus.restart !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d: got st=%0d plot=%b fd=%b rs=%b, want 0/0/0/0",
                     name, i, bus.state, bus.plot_en, bus.frame_done, bus.restart);
         end
      end
   endtask

   task automatic measure_frame(input logic [NS-1:0] mask);
      int n = 0;
      bus.sprite_en = mask;
      start_frame(1'b0, 0);
      while (bus.state !== 3'(ST_IDLE) && n < 1000) begin
         n++;
         tick();
      end
      checks++;
      if (n != frame_len(mask)) begin
         failures++;
         $display("[TB] FAIL frame_length mask=%b: got %0d cycles, want %0d", mask, n, frame_len(mask));
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.go        = 1'b0;
      bus.init_done = 1'b0;
      bus.dead      = 1'b0;
      bus.sprite_en = '1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.state !== 3'(ST_IDLE) || bus.sprite_sel !== '0 || bus.loc !== '0 ||
          bus.dx !== '0 || bus.dy !== '0) begin
         failures++;
         $display("[TB] FAIL reset_regs: got st=%0d sel=%0d loc=%0d dx=%0d dy=%0d, want all 0",
                  bus.state, bus.sprite_sel, bus.loc, bus.dx, bus.dy);
      end
      checks++;
      if (bus.plot_en !== 1'b0 || bus.erase !== 1'b0 || bus.load !== 1'b0 || bus.go_init !== 1'b0 ||
          bus.frame_done !== 1'b0 || bus.restart !== 1'b0 || bus.overrun !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_strobes: got plot=%b er=%b ld=%b gi=%b fd=%b rs=%b ov=%b, want all 0",
                  bus.plot_en, bus.erase, bus.load, bus.go_init, bus.frame_done, bus.restart, bus.overrun);
      end
   endtask

   task automatic test_first_frame();
      bus.sprite_en = 3'b111;
      start_frame(1'b1, 4);
      run_frame(3'b111, 1'b0, -1, -1, 1'b0);
      check_idle_quiet("frame_done_one_shot", 2);
   endtask

   task automatic test_back_to_back();
      bus.sprite_en = 3'b111;
      start_frame(1'b0, 0);
      run_frame(3'b111, 1'b0, -1, -1, 1'b0);
      measure_frame(3'b111);
   endtask

   task automatic test_mask();
      bus.sprite_en = 3'b101;
      start_frame(1'b0, 0);
      run_frame(3'b101, 1'b0, -1, -1, 1'b0);
      measure_frame(3'b101);
      measure_frame(3'b000);
   endtask

   task automatic test_restart();
      bus.sprite_en = 3'b111;
      start_frame(1'b0, 0);
      run_frame(3'b111, 1'b1, -1, -1, 1'b0);
      run_frame(3'b111, 1'b0, -1, -1, 1'b1);
   endtask

   task automatic test_overrun();
      bus.sprite_en = 3'b111;
      start_frame(1'b0, 0);
      run_frame(3'b111, 1'b0, NS * NPIX + 1 + NPIX + 7, -1, 1'b0);
      check_idle_quiet("overrun_no_new_frame", 4);
      start_frame(1'b0, 0);
      run_frame(3'b111, 1'b0, 2 * NS * NPIX + 1, -1, 1'b0);
      check_idle_quiet("overrun_in_comp", 3);
   endtask

   task automatic test_reset_mid_draw();
      bus.sprite_en = 3'b111;
      start_frame(1'b0, 0);
      run_frame(3'b111, 1'b0, -1, NS * NPIX + 1 + NPIX + 12, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.state !== 3'(ST_IDLE) || bus.sprite_sel !== '0 || bus.loc !== '0 ||
          bus.dx !== '0 || bus.dy !== '0 || bus.plot_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid_draw: got st=%0d sel=%0d loc=%0d dx=%0d dy=%0d plot=%b, want all 0",
                  bus.state, bus.sprite_sel, bus.loc, bus.dx, bus.dy, bus.plot_en);
      end
      check_idle_quiet("after_reset_quiet", 2);
      start_frame(1'b1, 2);
      run_frame(3'b111, 1'b0, -1, -1, 1'b0);
   endtask

   task automatic test_random_frames();
      logic [NS-1:0] mask;
      logic          dead_v;
      logic          by_restart;
      for (int f = 0; f < 10; f++) begin
         mask          = NS'($urandom);
         bus.sprite_en = mask;
         start_frame(1'b0, 0);
         by_restart = 1'b0;
         for (int r = 0; r < 3; r++) begin
            dead_v = (r < 2) && ($urandom_range(0, 2) == 0);
            run_frame(mask, dead_v, -1, -1, by_restart);
            by_restart = dead_v;
            if (!dead_v) break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_first_frame();
      test_back_to_back();
      test_mask();
      test_restart();
      test_overrun();
      test_reset_mid_draw();
      test_random_frames();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sprite_frame_sequencer.md
Name: sprite_frame_sequencer

Overview:
- Parametrised frame sequencer for the VGA game loop. Each frame it erases, reloads, redraws and collision-checks NUM_SPRITES sprites of SPRITE_W x SPRITE_H pixels.
- Generalises the fixed pellet/pacman/ghost sequencer:
  - arbitrary sprite count and size;
  - per-sprite enable mask;
  - explicit dx/dy pixel offsets;
  - one-shot init;
  - restart on death;
  - frame-overrun reporting.
- Sits between the rate divider tick and the per-sprite data registers and pixel muxes.

Parameters:
NUM_SPRITES, 3, number of sprites sequenced per frame (>=1)
SPRITE_W, 5, sprite width in pixels (>=1)
SPRITE_H, 5, sprite height in pixels (>=1)
Derived localparams:
- NPIX = SPRITE_W*SPRITE_H
- SEL_W = max(1, clog2(NUM_SPRITES))
- LOC_W = max(1, clog2(NPIX))
- DX_W = max(1, clog2(SPRITE_W))
- DY_W = max(1, clog2(SPRITE_H))

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  frame tick (one clock pulse from rate divider)
init_done  in  1  external init (e.g. pellet placement) finished
dead  in  1  collision/death flag, sampled in COMP
sprite_en  in  NUM_SPRITES  per-sprite enable mask (bit i = sprite i)
state  out  3  current state: IDLE=0, INIT=1, ERASE=2, LOAD=3, DRAW=4, COMP=5
sprite_sel  out  SEL_W  index of sprite being processed
loc  out  LOC_W  linear pixel index within sprite, 0..NPIX-1
dx  out  DX_W  loc mod SPRITE_W
dy  out  DY_W  loc div SPRITE_W
plot_en  out  1  pixel write strobe
erase  out  1  high throughout ERASE
load  out  1  high throughout LOAD (single cycle)
go_init  out  1  high throughout INIT
frame_done  out  1  one-cycle pulse on COMP->IDLE
restart  out  1  one-cycle pulse on COMP->ERASE due to dead
overrun  out  1  one-cycle pulse when go arrives outside IDLE

Behaviour:
Reset:
- State=IDLE; sprite_sel, loc, dx, dy = 0; init_pending=1.
- All strobes/pulses are 0 in the cycle after reset.
- Reset in any state aborts the frame the next edge; no further plot_en.

Outputs:
- Moore outputs (plot_en, erase, load, go_init) decode the registered state.
- sprite_sel/loc/dx/dy are registers; dx/dy update together with loc (counted alongside, no divider).

Transitions (evaluated each clock edge):
- IDLE: if go: ->INIT when init_pending, else ->ERASE. sprite_sel=0, loc=0.
- INIT: go_init=1; wait for init_done, then ->ERASE and clear init_pending. Never revisited until the next reset.
- ERASE / DRAW: sprite scan.
  - If sprite_en[sprite_sel]=1: plot_en=1 for NPIX cycles, loc 0..NPIX-1.
  - If sprite_en[sprite_sel]=0: one cycle, plot_en=0, loc held 0.
  - At loc=NPIX-1 (or the skip cycle): sprite_sel++ and loc=0; on the last sprite, sprite_sel=0 and advance ERASE->LOAD or DRAW->COMP.
- sprite_en is sampled per sprite at the cycle the sprite starts and held until that sprite finishes.
- LOAD: load=1 for exactly one cycle, then ->DRAW.
- COMP: one cycle.
  - dead=1: ->ERASE, restart pulse.
  - dead=0: ->IDLE, frame_done pulse.

Timing and boundaries:
- Frame length ERASE entry->IDLE with all sprites enabled: 2*NUM_SPRITES*NPIX+2 cycles (152 for defaults).
- go outside IDLE (including the cycle COMP->IDLE) is dropped and pulses overrun the same cycle. go is never queued.
- NUM_SPRITES=1 or NPIX=1: counters wrap every cycle; no special case.
- sprite_sel never exceeds NUM_SPRITES-1; loc never exceeds NPIX-1.

Test Plan:
- Reset, go pulse, init_done after 4 cycles (defaults, mask=3'b111):
  - state 0->1 (4 cycles)->2.
  - 75 ERASE cycles with plot_en=1, erase=1; loc 0..24 per sprite; sprite_sel 0,1,2; dx/dy (4,0) at loc=4, (0,1) at loc=5.
  - load for 1 cycle, 75 DRAW cycles, COMP, frame_done.
- Second go with dead=0: goes straight IDLE->ERASE (no INIT), go_init stays 0. Frame takes 152 cycles.
- mask=3'b101: sprite 1 takes 1 cycle with plot_en=0 in each phase. 50+1 plot cycles per phase; frame = 2*(51)+2 = 104 cycles.
- dead=1 in COMP: restart pulses and the next state is ERASE with sprite_sel=0, loc=0. dead=0 on the following COMP gives frame_done.
- go pulsed mid-DRAW: overrun pulses once, the frame completes unchanged, state returns to IDLE, and no new frame starts.
- reset asserted mid-DRAW (sprite_sel=1, loc=12):
  - next cycle state=IDLE, counters 0, plot_en=0.
  - next go enters INIT again.
